// File: rtl/knn_data_memory.sv
// ---------------------------------------------------------------------------
// knn_data_memory
//
// Word-addressed data memory behind the KNN memory controller. It holds the
// training records, the input records and the inferred-type results. Reads
// come back through a fixed-latency pipeline. A host port preloads datasets
// and reads back results while it owns the memory (host_sel = 1). Status
// counters and sticky error flags support bring-up.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   read             controller read strobe, one word per high cycle
//   readaddress      controller read address (byte-style, stride W)
//   readdata         read data, held until the next read completes
//   readdatavalid    one-cycle pulse when readdata updates
//   write            controller write strobe
//   writeaddress     controller write address
//   writedata        controller write data
//   host_sel         1 = host owns the memory; controller requests dropped
//   host_we/host_re  host write/read strobes (word index addressing)
//   host_addr        host word index
//   host_wdata       host write data
//   host_rdata       host read data, registered, 1-cycle latency
//   host_rvalid      one-cycle pulse one cycle after host_re
//   write_count      accepted controller writes, saturating
//   last_write_addr  address of the most recent accepted controller write
//   err_range        sticky: out-of-range or misaligned controller access
//   err_busy         sticky: controller request while host_sel = 1
// ---------------------------------------------------------------------------
module knn_data_memory #(
  parameter int                W            = 32,
  parameter int                ADDR_W       = 16,
  parameter int                DEPTH        = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     read,
  input  logic [ADDR_W-1:0]        readaddress,
  output logic [W-1:0]             readdata,
  output logic                     readdatavalid,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        writeaddress,
  input  logic [W-1:0]             writedata,
  input  logic                     host_sel,
  input  logic                     host_we,
  input  logic                     host_re,
  input  logic [$clog2(DEPTH)-1:0] host_addr,
  input  logic [W-1:0]             host_wdata,
  output logic [W-1:0]             host_rdata,
  output logic                     host_rvalid,
  output logic [15:0]              write_count,
  output logic [ADDR_W-1:0]        last_write_addr,
  output logic                     err_range,
  output logic                     err_busy
);

  localparam int              LG_W    = $clog2(W);
  localparam int              AW      = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  typedef struct packed {
    logic          ok;
    logic [AW-1:0] idx;
  } dec_t;

  // Address decode. The subtraction is done one bit wider so that its borrow
  // flags addresses below BASE_ADDR without a constant compare.
  function automatic dec_t decode(input logic [ADDR_W-1:0] addr);
    dec_t              d;
    logic              borrow;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] word;
    {borrow, off} = {1'b0, addr} - {1'b0, BASE_ADDR};
    word          = off >> LG_W;
    d.ok          = !borrow && (off[LG_W-1:0] == '0) && ({1'b0, word} < DEPTH_X);
    d.idx         = word[AW-1:0];
    return d;
  endfunction

  logic [W-1:0] r_mem [DEPTH];

  dec_t          w_rd_dec;
  dec_t          w_wr_dec;
  logic          w_ctl_rd;
  logic          w_ctl_wr;
  logic          w_wr_accept;
  logic          w_host_rd;
  logic          w_mem_we;
  logic [AW-1:0] w_mem_waddr;
  logic [W-1:0]  w_mem_wdata;

  assign w_rd_dec    = decode(readaddress);
  assign w_wr_dec    = decode(writeaddress);
  assign w_ctl_rd    = read  & ~host_sel;
  assign w_ctl_wr    = write & ~host_sel;
  assign w_wr_accept = w_ctl_wr & w_wr_dec.ok;
  assign w_host_rd   = host_re & host_sel;

  // host_sel picks the single writer, so the RAM has one write port.
  assign w_mem_we    = host_sel ? host_we    : w_wr_accept;
  assign w_mem_waddr = host_sel ? host_addr  : w_wr_dec.idx;
  assign w_mem_wdata = host_sel ? host_wdata : writedata;

  // NOTE: the RAM array has no reset; clearing it would turn it into flops
  // and would also wipe preloaded datasets, which must survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
  end

  // Read pipeline: stage 0 samples the RAM (old data on a same-cycle write),
  // the last stage drives readdata. Data stages only advance behind a valid
  // bit, so readdata holds its value between completed reads.
  logic [READ_LATENCY-1:0] r_vld;
  logic [W-1:0]            r_dat [READ_LATENCY];

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, which gives the shift and read-before-write
  // behaviour regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        r_dat[k] <= '0;
      end
    end else begin
      r_vld[0] <= w_ctl_rd;
      if (w_ctl_rd) begin
        // An invalid address still completes, returning zero.
        r_dat[0] <= w_rd_dec.ok ? r_mem[w_rd_dec.idx] : '0;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        if (r_vld[k-1]) begin
          r_dat[k] <= r_dat[k-1];
        end
      end
    end
  end

  assign readdata      = r_dat[READ_LATENCY-1];
  assign readdatavalid = r_vld[READ_LATENCY-1];

  logic [W-1:0]        r_host_rdata;
  logic                r_host_rvalid;
  logic [15:0]         r_write_count;
  logic [ADDR_W-1:0]   r_last_write_addr;
  logic                r_err_range;
  logic                r_err_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_host_rdata      <= '0;
      r_host_rvalid     <= 1'b0;
      r_write_count     <= '0;
      r_last_write_addr <= BASE_ADDR;
      r_err_range       <= 1'b0;
      r_err_busy        <= 1'b0;
    end else begin
      r_host_rvalid <= w_host_rd;
      if (w_host_rd) begin
        r_host_rdata <= r_mem[host_addr];
      end
      if (w_wr_accept) begin
        if (r_write_count != 16'hFFFF) begin
          r_write_count <= r_write_count + 16'd1;
        end
        r_last_write_addr <= writeaddress;
      end
      if ((w_ctl_rd && !w_rd_dec.ok) || (w_ctl_wr && !w_wr_dec.ok)) begin
        r_err_range <= 1'b1;
      end
      if (host_sel && (read || write)) begin
        r_err_busy <= 1'b1;
      end
    end
  end

  assign host_rdata      = r_host_rdata;
  assign host_rvalid     = r_host_rvalid;
  assign write_count     = r_write_count;
  assign last_write_addr = r_last_write_addr;
  assign err_range       = r_err_range;
  assign err_busy        = r_err_busy;

endmodule
